// File: rtl/score_panel_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : score_panel_ctrl
// Purpose  : Paints the score panel into the shared background tile RAM.
//            Walks the PANEL_W x PANEL_H label ROM, then writes DIGITS BCD
//            score glyphs on the row below the label. The tile RAM write port
//            is shared with the board renderer through a req/grant handshake.
//            Redraw and score-update requests are coalesced so that a digit
//            row is always written from one consistent score snapshot.
// Ports    : Clk, Reset      - clock, synchronous active-high reset
//            START           - pulse, repaint label plus digits
//            SCORE_UPD       - pulse, SCORE_BCD carries a new score
//            SCORE_BCD       - score, most significant nibble first
//            BASE_ADDR       - tile RAM address of panel top-left
//            CHAR_ADDR/DATA  - combinational label ROM interface
//            TILE_REQ/GNT    - tile RAM write request / accept
//            TILE_ADDR/DATA  - tile RAM write address / data
//            BUSY, DONE      - sequence active / one-cycle end pulse
// Options  : LEADING_ZERO_BLANK_EN - when defined, zero digits ahead of the
//            first non-zero digit are written blank (8'h00); the least
//            significant digit always shows its glyph.
// Revision : 1.0 - initial release
// ============================================================================
module score_panel_ctrl #(
    parameter int         PANEL_W    = 7,
    parameter int         PANEL_H    = 6,
    parameter int         MAP_PITCH  = 32,
    parameter int         ADDR_W     = 10,
    parameter int         DIGITS     = 6,
    parameter logic [7:0] DIGIT_BASE = 8'h30
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                START,
    input  logic                SCORE_UPD,
    input  logic [4*DIGITS-1:0] SCORE_BCD,
    input  logic [ADDR_W-1:0]   BASE_ADDR,
    output logic [5:0]          CHAR_ADDR,
    input  logic [7:0]          CHAR_DATA,
    output logic                TILE_REQ,
    input  logic                TILE_GNT,
    output logic [ADDR_W-1:0]   TILE_ADDR,
    output logic [7:0]          TILE_DATA,
    output logic                BUSY,
    output logic                DONE
);

    localparam int c_ROW_W = (PANEL_H > 1) ? $clog2(PANEL_H) : 1;
    localparam int c_COL_W = (PANEL_W > 1) ? $clog2(PANEL_W) : 1;
    localparam int c_DIG_W = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;

    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(PANEL_H - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(PANEL_W - 1);
    localparam logic [c_DIG_W-1:0] c_LAST_DIG = c_DIG_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LABEL = 2'd1,
        S_DIGIT = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_ROW_W-1:0]    r_row;
    logic [c_COL_W-1:0]    r_col;
    logic [c_DIG_W-1:0]    r_dig;
    logic [4*DIGITS-1:0]   r_score;
    logic [4*DIGITS-1:0]   r_work;
    logic [ADDR_W-1:0]     r_base;
    logic                  r_redraw_pend;
    logic                  r_score_pend;

    logic                  w_tile_last;
    logic                  w_dig_last;
    logic                  w_leave_idle;
    logic                  w_enter_digit;
    logic [3:0]            w_nib;
    logic                  w_blank_lead;
    logic [7:0]            w_digit_data;
    logic [5:0]            w_char_addr;
    logic [ADDR_W-1:0]     w_label_addr;
    logic [ADDR_W-1:0]     w_digit_addr;

    assign w_tile_last   = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
    assign w_dig_last    = (r_dig == c_LAST_DIG);
    assign w_leave_idle  = (r_state == S_IDLE) && (w_next != S_IDLE);
    assign w_enter_digit = (w_next == S_DIGIT) && (r_state != S_DIGIT);

    assign w_char_addr  = 6'(r_row) * 6'(PANEL_W) + 6'(r_col);
    assign w_label_addr = r_base + ADDR_W'(r_row) * ADDR_W'(MAP_PITCH) + ADDR_W'(r_col);
    assign w_digit_addr = r_base + ADDR_W'(PANEL_H * MAP_PITCH) + ADDR_W'(r_dig);

    // Digit 0 is the most significant nibble of the snapshot.
    always_comb begin
        w_nib = 4'd0;
        for (int j = 0; j < DIGITS; j++) begin
            if (r_dig == c_DIG_W'(j)) begin
                w_nib = r_work[4*(DIGITS-1-j) +: 4];
            end
        end
    end

    // Leading-zero run: every nibble up to and including the current one is
    // zero. The last digit is excluded so a zero score still shows "0".
    always_comb begin
        w_blank_lead = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank_lead = !w_dig_last;
        for (int j = 0; j < DIGITS; j++) begin
            if ((c_DIG_W'(j) <= r_dig) && (r_work[4*(DIGITS-1-j) +: 4] != 4'd0)) begin
                w_blank_lead = 1'b0;
            end
        end
`endif
    end

    assign w_digit_data = ((w_nib > 4'd9) || w_blank_lead) ? 8'h00
                                                           : DIGIT_BASE + {4'd0, w_nib};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        CHAR_ADDR = 6'd0;
        TILE_REQ  = 1'b0;
        TILE_ADDR = '0;
        TILE_DATA = 8'h00;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A repaint always includes a digit pass, so it wins.
                if (START || r_redraw_pend) begin
                    w_next = S_LABEL;
                end else if (SCORE_UPD || r_score_pend) begin
                    w_next = S_DIGIT;
                end
            end
            S_LABEL: begin
                CHAR_ADDR = w_char_addr;
                TILE_REQ  = 1'b1;
                TILE_ADDR = w_label_addr;
                TILE_DATA = CHAR_DATA;
                BUSY      = 1'b1;
                if (TILE_GNT && w_tile_last) begin
                    w_next = S_DIGIT;
                end
            end
            S_DIGIT: begin
                TILE_REQ  = 1'b1;
                TILE_ADDR = w_digit_addr;
                TILE_DATA = w_digit_data;
                BUSY      = 1'b1;
                if (TILE_GNT && w_dig_last) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                DONE   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_row         <= '0;
            r_col         <= '0;
            r_dig         <= '0;
            r_score       <= '0;
            r_work        <= '0;
            r_base        <= '0;
            r_redraw_pend <= 1'b0;
            r_score_pend  <= 1'b0;
        end else begin
            if (SCORE_UPD) begin
                r_score <= SCORE_BCD;
            end

            // An update landing on the entry edge is consumed by this pass,
            // otherwise it is deferred to one further digit pass.
            if (w_enter_digit) begin
                r_work       <= SCORE_UPD ? SCORE_BCD : r_score;
                r_score_pend <= 1'b0;
                r_dig        <= '0;
            end else if (SCORE_UPD) begin
                r_score_pend <= 1'b1;
            end

            if (w_leave_idle) begin
                r_base <= BASE_ADDR;
            end

            if ((r_state == S_IDLE) && (w_next == S_LABEL)) begin
                r_redraw_pend <= 1'b0;
            end else if (START && (r_state != S_IDLE)) begin
                r_redraw_pend <= 1'b1;
            end

            if ((r_state == S_LABEL) && TILE_GNT) begin
                if (r_col == c_LAST_COL) begin
                    r_col <= '0;
                    r_row <= w_tile_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if ((r_state == S_DIGIT) && TILE_GNT) begin
                r_dig <= w_dig_last ? '0 : r_dig + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
